// File: rtl/mux41_rr_arbiter_pkg.sv
// rtl/mux41_rr_arbiter_pkg.sv - shared state encoding, requester indices and round-robin pick helper
package mux41_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Scan from ptr upward mod 4; walking offsets high-to-low lets the nearest one win.
    function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        pick_t      r;
        logic [1:0] k;
        r.found = 1'b0;
        r.idx   = ptr;
        for (int i = 3; i >= 0; i--) begin
            k = ptr + 2'(i);
            if (req[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux41_sel.sv
// rtl/mux41_sel.sv - combinational 1-bit 4:1 mux with a 2-bit select {s1,s0}
module mux41_sel (
    input  logic [3:0] d,
    input  logic       s1,
    input  logic       s0,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case ({s1, s0})
            2'b00:   y = d[0];
            2'b01:   y = d[1];
            2'b10:   y = d[2];
            default: y = d[3];
        endcase
    end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// rtl/mux41_rr_arbiter.sv - round-robin arbiter for a shared 4:1 mux with bounded tenure and gap cycle
module mux41_rr_arbiter
    import mux41_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] data_in,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       valid,
    output logic       data_out,
    output logic       preempt
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic       data_out_q, data_out_d;
    logic       preempt_q, preempt_d;
    logic       mux_y;
    pick_t      pick;

    always_comb pick = rr_pick(req, ptr_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = 4'b0000;
        valid_d    = 1'b0;
        preempt_d  = 1'b0;
        case (state_q)
            GRANT: begin
                if (!req[sel_q]) begin
                    state_d = GAP;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = GAP;
                    preempt_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                    gnt_d      = gnt_q;
                    valid_d    = 1'b1;
                end
            end
            default: begin
                // IDLE and GAP arbitrate; sel keeps its last value when nobody wins
                if (pick.found) begin
                    state_d    = GRANT;
                    gnt_d      = onehot4(pick.idx);
                    sel_d      = pick.idx;
                    ptr_d      = pick.idx + 2'd1;
                    hold_cnt_d = 8'd0;
                    valid_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Select with the next-cycle index so data_out is correct in the first granted cycle.
    mux41_sel u_sel (
        .d  (data_in),
        .s1 (sel_d[1]),
        .s0 (sel_d[0]),
        .y  (mux_y)
    );

    always_comb data_out_d = valid_d & mux_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= REQ_A;
            sel_q      <= 2'd0;
            hold_cnt_q <= 8'd0;
            gnt_q      <= 4'b0000;
            valid_q    <= 1'b0;
            data_out_q <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
            preempt_q  <= preempt_d;
        end
    end

    assign gnt      = gnt_q;
    assign s1       = sel_q[1];
    assign s0       = sel_q[0];
    assign valid    = valid_q;
    assign data_out = data_out_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// tb/tb_mux41_rr_arbiter.sv - scoreboard bench over three arbiter instances (MAX_HOLD 8, 2, 1)
module tb_mux41_rr_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req  [3];
    logic [3:0] din  [3];
    logic [3:0] gnt  [3];
    logic       s0   [3];
    logic       s1   [3];
    logic       valid[3];
    logic       dout [3];
    logic       pre  [3];

    exp_t       sb [3][$];
    int         pre_cnt [3] = '{0, 0, 0};
    logic       prev_v  [3] = '{1'b0, 1'b0, 1'b0};
    logic [3:0] prev_g  [3] = '{4'b0, 4'b0, 4'b0};
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mux41_rr_arbiter #(.MAX_HOLD(k == 0 ? 8 : (k == 1 ? 2 : 1))) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req      (req[k]),
            .data_in  (din[k]),
            .gnt      (gnt[k]),
            .s0       (s0[k]),
            .s1       (s1[k]),
            .valid    (valid[k]),
            .data_out (dout[k]),
            .preempt  (pre[k])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int k, input int w, input int n, input logic [3:0] d);
        exp_t e;
        e.gnt = 4'b0001 << w;
        e.sel = 2'(w);
        e.d   = d[w];
        repeat (n) sb[k].push_back(e);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            exp_t got;
            got = {gnt[k], s1[k], s0[k], dout[k]};
            checks++;
            if (!(gnt[k] == 4'b0 || $onehot(gnt[k])) || ((gnt[k] != 4'b0) != valid[k])) begin
                errors++;
                $display("FAIL inv%0d: gnt=%b valid=%b", k, gnt[k], valid[k]);
            end
            if (pre[k]) begin
                pre_cnt[k]++;
                checks++;
                if (valid[k]) begin
                    errors++;
                    $display("FAIL preempt_in_grant%0d: valid=%b expected 0", k, valid[k]);
                end
            end
            if (valid[k]) begin
                checks++;
                if (sb[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant%0d: gnt=%b sel=%b%b", k, gnt[k], s1[k], s0[k]);
                end else begin
                    e = sb[k].pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL grant%0d: got gnt=%b sel=%b d=%b expected gnt=%b sel=%b d=%b",
                                 k, got.gnt, got.sel, got.d, e.gnt, e.sel, e.d);
                    end
                end
                if (prev_v[k]) begin
                    checks++;
                    if (gnt[k] !== prev_g[k]) begin
                        errors++;
                        $display("FAIL adjacent%0d: got gnt=%b after %b with no gap", k, gnt[k], prev_g[k]);
                    end
                end
            end
            prev_v[k] = valid[k];
            prev_g[k] = gnt[k];
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        logic [3:0] ev;
        logic [3:0] ep;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 4'b0;
            din[k] = 4'b0;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_gnt", int'(gnt[k]), 0);
            chk("reset_out", int'({s1[k], s0[k], valid[k], dout[k], pre[k]}), 0);
        end
        tick(2);
        rst = 1'b0;

        // single requester C, held 3 cycles
        req[0] = 4'b0100; din[0] = 4'b0100;
        push(0, 2, 3, din[0]);
        chk("t1_latency_before", int'(valid[0]), 0);
        tick(1);
        chk("t1_latency_gnt", int'(gnt[0]), 4'b0100);
        tick(2);
        req[0] = 4'b0;
        tick(1);
        chk("t1_gap_valid", int'(valid[0]), 0);
        chk("t1_gap_sel_hold", int'({s1[0], s0[0]}), 2);
        tick(1);
        chk("t1_idle_gnt", int'(gnt[0]), 0);
        chk("t1_idle_sel_hold", int'({s1[0], s0[0]}), 2);
        chk("t1_sb_empty", sb[0].size(), 0);
        chk("t1_no_preempt", pre_cnt[0], 0);

        // round robin with all requesting, MAX_HOLD=2
        req[1] = 4'b1111; din[1] = 4'b0101;
        push(1, 0, 2, din[1]);
        push(1, 1, 2, din[1]);
        push(1, 2, 2, din[1]);
        push(1, 3, 2, din[1]);
        push(1, 0, 2, din[1]);
        tick(15);
        req[1] = 4'b0;
        tick(3);
        chk("t2_sb_empty", sb[1].size(), 0);
        chk("t2_preempts", pre_cnt[1], 5);

        // pointer skip: move ptr to 2, then req=0011 grants 0 then 1
        req[0] = 4'b0010; din[0] = 4'b0010;
        push(0, 1, 1, din[0]);
        tick(1);
        req[0] = 4'b0;
        tick(1);
        req[0] = 4'b0011;
        push(0, 0, 8, din[0]);
        push(0, 1, 1, din[0]);
        tick(10);
        req[0] = 4'b0;
        tick(3);
        chk("t3_sb_empty", sb[0].size(), 0);
        chk("t3_preempts", pre_cnt[0], 1);

        // early release of requester D
        req[0] = 4'b1000; din[0] = 4'b1000;
        push(0, 3, 1, din[0]);
        tick(1);
        chk("t4_gnt", int'(gnt[0]), 4'b1000);
        req[0] = 4'b0;
        tick(1);
        chk("t4_gap_valid", int'(valid[0]), 0);
        chk("t4_gap_preempt", int'(pre[0]), 0);
        tick(2);
        chk("t4_sb_empty", sb[0].size(), 0);
        chk("t4_preempts", pre_cnt[0], 1);

        // asynchronous reset mid-tenure
        req[0] = 4'b0100; din[0] = 4'b0110;
        push(0, 2, 1, din[0]);
        tick(2);
        chk("t5_pre_reset_gnt", int'(gnt[0]), 4'b0100);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_gnt", int'(gnt[0]), 0);
        chk("t5_rst_out", int'({s1[0], s0[0], valid[0], dout[0], pre[0]}), 0);
        rst = 1'b0;
        req[0] = 4'b0010;
        push(0, 1, 1, din[0]);
        tick(1);
        chk("t5_restart_gnt", int'(gnt[0]), 4'b0010);
        req[0] = 4'b0;
        tick(3);
        chk("t5_sb_empty", sb[0].size(), 0);

        // MAX_HOLD=1 with requester A held
        ev = 4'b0101;
        ep = 4'b1010;
        req[2] = 4'b0001; din[2] = 4'b0001;
        push(2, 0, 2, din[2]);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("t6_valid_seq", int'(valid[2]), int'(ev[i]));
            chk("t6_preempt_seq", int'(pre[2]), int'(ep[i]));
        end
        req[2] = 4'b0;
        tick(3);
        chk("t6_sb_empty", sb[2].size(), 0);
        chk("t6_preempts", pre_cnt[2], 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter that shares a single 1-bit 4:1 mux output between four requesters.
- Generates the mux select pair (s1,s0), a one-hot grant and a registered data output.
- Enforces a maximum grant tenure with forced preemption.
- Inserts a one-cycle turnaround gap between tenures so no two grants are ever adjacent.

Parameters:
- MAX_HOLD, 8, maximum consecutive GRANT cycles for one requester; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i (A=0, B=1, C=2, D=3).
- data_in  input  4  per-requester data bits, same bit order as req.
- gnt  output  4  one-hot grant, registered; all zeros when no grant.
- s0  output  1  mux select LSB, registered.
- s1  output  1  mux select MSB, registered; {s1,s0} = index of granted requester.
- valid  output  1  high while in GRANT.
- data_out  output  1  registered data_in[{s1,s0}] while granted, else 0.
- preempt  output  1  one-cycle pulse when a tenure ends by MAX_HOLD expiry.

Behaviour:
- Reset (asynchronous, immediate):
  - gnt=0, s1=0, s0=0, valid=0, data_out=0, preempt=0.
  - state=IDLE, ptr=0, hold_cnt=0.
- States: IDLE, GRANT, GAP.
- Arbitration (evaluated only in IDLE and GAP):
  - Winner = first i with req[i]=1, scanning from ptr upward modulo 4.
  - If a winner exists: next state GRANT; gnt<=onehot(winner); {s1,s0}<=winner; ptr<=(winner+1) mod 4; hold_cnt<=0.
  - Otherwise: next state IDLE, outputs idle.
- GRANT:
  - valid=1.
  - Each cycle, sample the granted requester's req bit g:
    - g=0 → GAP next cycle; tenure ends with no preempt.
    - g=1 and hold_cnt==MAX_HOLD-1 → GAP next cycle; preempt=1 for exactly that transition cycle.
    - Otherwise: hold_cnt increments and state stays GRANT.
  - Maximum tenure is therefore exactly MAX_HOLD cycles of valid.
  - Requests from other requesters never shorten the current tenure.
- GAP:
  - gnt=0, valid=0, data_out=0 for exactly one cycle; then arbitrate as above.
  - {s1,s0} holds its last value during GAP and IDLE, so the mux does not toggle needlessly.
- Latency:
  - req rising in IDLE → gnt/valid high on the next rising edge (1 cycle).
  - data_out = data_in[sel] sampled on the same edge, i.e. 1 cycle behind data_in.
- Fairness:
  - A continuously requesting requester waits at most 3 × (MAX_HOLD+1) cycles.
- MAX_HOLD=1: each tenure is 1 cycle, and preempt fires every tenure while req is held.
- ptr wraps 3→0.
- Reset asserted mid-tenure: all outputs clear asynchronously; after deassertion, arbitration restarts from ptr=0.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt nonzero ⇔ valid.
  - When valid=1, gnt[{s1,s0}]=1.

Decomposition:
- Shared package (lab-wide):
  - State encoding localparams: IDLE=2'd0, GRANT=2'd1, GAP=2'd2.
  - Requester index constants REQ_A..REQ_D.
- One sub-module, mux41_sel: combinational 4:1 mux using a true 2-bit select {s1,s0}. It feeds the data_out register.

Test Plan:
- Single requester: req=4'b0100 held 3 cycles then dropped; data_in[2]=1 → gnt=4'b0100, {s1,s0}=2'b10, valid for 3 cycles; data_out=1 one cycle later; then GAP, then IDLE.
- Round-robin: req=4'b1111 held, MAX_HOLD=2 → grant order 0,1,2,3,0. Each tenure is 2 valid cycles, with a 1-cycle gap and preempt pulse at each expiry.
- Pointer skip: ptr=2, req=4'b0011 → grant to requester 0, then ptr=1. With req still 4'b0011, requester 1 is granted after the gap.
- Early release: grant to 3, req[3] drops after 1 cycle, MAX_HOLD=8 → GAP next cycle, preempt stays 0.
- Async reset mid-GRANT: rst pulsed between clock edges → gnt, valid, data_out and preempt go 0 immediately. After release with req=4'b0010, requester 1 is granted on the first edge.
- MAX_HOLD=1, req=4'b0001 held → valid toggles 1,0,1,0; preempt pulses on every tenure end.
